// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between ex/front-end and the pipeline sequencing controller.
interface pipe_ctrl_if;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_ex_i;
    logic        mc_req_i;
    logic        mc_done_i;
    logic        halt_req_i;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        hold_pc_o;
    logic        hold_if_id_o;
    logic        hold_id_ex_o;
    logic        flush_o;
    logic        halted_o;
    logic        mc_timeout_o;

    modport master (
        output jump_en_i, jump_addr_i, hold_flag_ex_i, mc_req_i, mc_done_i, halt_req_i,
        input  jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
               flush_o, halted_o, mc_timeout_o
    );

    modport slave (
        input  jump_en_i, jump_addr_i, hold_flag_ex_i, mc_req_i, mc_done_i, halt_req_i,
        output jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
               flush_o, halted_o, mc_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: PC redirect, stage holds and wrong-path flush.
// Optional multi-cycle watchdog enabled by defining PIPE_CTRL_MC_TIMEOUT_EN.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MC_TIMEOUT   = 64
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, FLUSH, MC_WAIT, HALT} state_t;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    state_t     state;
    logic [3:0] flush_cnt;
    logic       halted;
    logic       jump_en;
    logic       hold;
    logic       flush;
    logic       mc_release;

`ifdef PIPE_CTRL_MC_TIMEOUT_EN
    localparam int unsigned WCW = $clog2(MC_TIMEOUT + 1);
    logic [WCW-1:0] wait_cnt;
    logic           mc_forced;
    logic           mc_timeout;

    assign mc_forced  = (state == MC_WAIT) && !bus.mc_done_i &&
                        (wait_cnt == WCW'(MC_TIMEOUT - 1));
    assign mc_release = bus.mc_done_i || mc_forced;
    assign bus.mc_timeout_o = mc_timeout;
`else
    assign mc_release = bus.mc_done_i;
    assign bus.mc_timeout_o = 1'b0;
`endif

    // Outputs are gated by reset so they read 0 the instant rst falls.
    always_comb begin
        jump_en = 1'b0;
        hold    = 1'b0;
        flush   = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    if (bus.jump_en_i) begin
                        jump_en = 1'b1;
                        flush   = 1'b1;
                    end else if (bus.mc_req_i || bus.hold_flag_ex_i || bus.halt_req_i) begin
                        hold = 1'b1;
                    end
                end
                FLUSH: begin
                    flush   = 1'b1;
                    jump_en = bus.jump_en_i;
                end
                MC_WAIT: hold = !mc_release;
                HALT:    hold = bus.halt_req_i;
                default: ;
            endcase
        end
    end

    assign bus.jump_en_o    = jump_en;
    assign bus.jump_addr_o  = jump_en ? bus.jump_addr_i : '0;
    assign bus.hold_pc_o    = hold;
    assign bus.hold_if_id_o = hold;
    assign bus.hold_id_ex_o = hold;
    assign bus.flush_o      = flush;
    assign bus.halted_o     = halted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            flush_cnt <= '0;
            halted    <= 1'b0;
`ifdef PIPE_CTRL_MC_TIMEOUT_EN
            wait_cnt   <= '0;
            mc_timeout <= 1'b0;
`endif
        end else begin
            // Registered view of "still halted next cycle", so it lags entry by one cycle.
            halted <= (state == HALT) && bus.halt_req_i;
            case (state)
                RUN: begin
                    if (bus.jump_en_i) begin
                        if (MULTI_FLUSH) begin
                            flush_cnt <= FLUSH_RELOAD;
                            state     <= FLUSH;
                        end
                    end else if (bus.mc_req_i) begin
                        state <= MC_WAIT;
`ifdef PIPE_CTRL_MC_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else if (bus.hold_flag_ex_i) begin
                        state <= RUN;
                    end else if (bus.halt_req_i) begin
                        state <= HALT;
                    end
                end
                FLUSH: begin
                    if (bus.jump_en_i) begin
                        flush_cnt <= FLUSH_RELOAD;
                    end else if (flush_cnt == 4'd1) begin
                        flush_cnt <= '0;
                        state     <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                MC_WAIT: begin
                    if (mc_release) state <= RUN;
`ifdef PIPE_CTRL_MC_TIMEOUT_EN
                    if (wait_cnt != WCW'(MC_TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
                    if (mc_forced) mc_timeout <= 1'b1;
`endif
                end
                HALT: begin
                    if (!bus.halt_req_i) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (FLUSH_CYCLES=2, MC_TIMEOUT=8).
module tb_pipe_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pipe_ctrl_if bus();

    pipe_ctrl #(.FLUSH_CYCLES(2), .MC_TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed order: jump_en, hold_pc, hold_if_id, hold_id_ex, flush, halted, mc_timeout
    logic [6:0] obs;
    assign obs = {bus.jump_en_o, bus.hold_pc_o, bus.hold_if_id_o, bus.hold_id_ex_o,
                  bus.flush_o, bus.halted_o, bus.mc_timeout_o};

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] HOLD = 7'b0111000;
    localparam logic [6:0] JF   = 7'b1000100;
    localparam logic [6:0] FL   = 7'b0000100;
    localparam logic [6:0] HLTD = 7'b0000010;

    logic [6:0] tmo;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        tmo      = NONE;
        bus.jump_en_i      = 1'b0;
        bus.jump_addr_i    = '0;
        bus.hold_flag_ex_i = 1'b0;
        bus.mc_req_i       = 1'b0;
        bus.mc_done_i      = 1'b0;
        bus.halt_req_i     = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        bus.hold_flag_ex_i = 1'b1;
        bus.jump_addr_i    = 32'h0000_0abc;
        settle();
        chk("reset_outs", obs, NONE);
        chk("reset_addr", bus.jump_addr_o, 32'h0);
        bus.hold_flag_ex_i = 1'b0;
        tick();
        rst = 1'b1;
        settle();
        chk("run_idle", obs, NONE);

        // Jump with two-cycle flush
        bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'h0000_0100;
        settle();
        chk("jump_outs", obs, JF);
        chk("jump_addr", bus.jump_addr_o, 32'h100);
        tick();
        bus.jump_en_i = 1'b0; bus.jump_addr_i = 32'hdead_beef;
        settle();
        chk("flush_2nd", obs, FL);
        chk("flush_addr0", bus.jump_addr_o, 32'h0);
        tick();
        settle();
        chk("flush_done", obs, NONE);

        // Single-cycle ex hold
        bus.hold_flag_ex_i = 1'b1;
        settle();
        chk("ex_hold", obs, HOLD);
        tick();
        bus.hold_flag_ex_i = 1'b0;
        settle();
        chk("ex_hold_end", obs, NONE);

        // Re-jump during FLUSH reloads the counter
        bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'h0000_0200;
        settle();
        chk("rj_first", obs, JF);
        tick();
        bus.jump_addr_i = 32'h0000_0300;
        settle();
        chk("rj_in_flush", obs, JF);
        chk("rj_addr", bus.jump_addr_o, 32'h300);
        tick();
        bus.jump_en_i = 1'b0;
        settle();
        chk("rj_reload", obs, FL);
        tick();
        settle();
        chk("rj_done", obs, NONE);

        // Multi-cycle wait: req + 5 wait cycles held, released on done
        bus.mc_req_i = 1'b1;
        settle();
        chk("mc_req", obs, HOLD);
        tick();
        bus.mc_req_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.jump_en_i      = (i == 2);
            bus.hold_flag_ex_i = (i == 3);
            bus.mc_req_i       = (i == 4);
            bus.jump_addr_i    = 32'h0000_0400;
            settle();
            chk("mc_wait", obs, HOLD);
            chk("mc_wait_addr", bus.jump_addr_o, 32'h0);
            tick();
        end
        bus.jump_en_i = 1'b0; bus.hold_flag_ex_i = 1'b0; bus.mc_req_i = 1'b0;
        bus.mc_done_i = 1'b1;
        settle();
        chk("mc_done", obs, NONE);
        tick();
        settle();
        chk("mc_after", obs, NONE);
        tick();
        settle();
        chk("done_in_run", obs, NONE);
        tick();
        bus.mc_done_i = 1'b0;
        settle();
        chk("done_in_run2", obs, NONE);

        // Priority: jump beats mc_req and halt; halt follows the flush
        bus.jump_en_i = 1'b1; bus.mc_req_i = 1'b1; bus.halt_req_i = 1'b1;
        bus.jump_addr_i = 32'h0000_0500;
        settle();
        chk("prio_jump", obs, JF);
        chk("prio_addr", bus.jump_addr_o, 32'h500);
        tick();
        bus.jump_en_i = 1'b0; bus.mc_req_i = 1'b0;
        settle();
        chk("prio_flush", obs, FL);
        tick();
        settle();
        chk("prio_halt_req", obs, HOLD);
        tick();
        settle();
        chk("halt_entry", obs, HOLD);
        tick();
        settle();
        chk("halted_set", obs, HOLD | HLTD);
        tick();
        bus.jump_en_i = 1'b1;
        settle();
        chk("halt_no_jump", obs, HOLD | HLTD);
        tick();
        bus.jump_en_i = 1'b0; bus.halt_req_i = 1'b0;
        settle();
        chk("halt_release", obs, HLTD);
        tick();
        settle();
        chk("halted_clr", obs, NONE);
        tick();
        settle();
        chk("no_mc_residue", obs, NONE);

        // Halt arriving during MC_WAIT is deferred until done
        bus.mc_req_i = 1'b1;
        settle();
        chk("hm_req", obs, HOLD);
        tick();
        bus.mc_req_i = 1'b0; bus.halt_req_i = 1'b1;
        settle();
        chk("hm_wait1", obs, HOLD);
        tick();
        settle();
        chk("hm_wait2", obs, HOLD);
        tick();
        bus.mc_done_i = 1'b1;
        settle();
        chk("hm_done", obs, NONE);
        tick();
        bus.mc_done_i = 1'b0;
        settle();
        chk("hm_run_halt", obs, HOLD);
        tick();
        settle();
        chk("hm_halt", obs, HOLD);
        tick();
        settle();
        chk("hm_halted", obs, HOLD | HLTD);
        tick();
        bus.halt_req_i = 1'b0;
        settle();
        chk("hm_release", obs, HLTD);
        tick();
        settle();
        chk("hm_clr", obs, NONE);

        // Multi-cycle timeout behaviour
        bus.mc_req_i = 1'b1;
        settle();
        chk("to_req", obs, HOLD);
        tick();
        bus.mc_req_i = 1'b0;
`ifdef PIPE_CTRL_MC_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            settle();
            chk("to_wait", obs, HOLD);
            tick();
        end
        settle();
        chk("to_forced", obs, NONE);
        tick();
        settle();
        chk("to_flag", obs, 7'b0000001);
        tick();
        settle();
        chk("to_sticky", obs, 7'b0000001);
        tmo = 7'b0000001;
`else
        for (int i = 0; i < 105; i++) begin
            settle();
            chk("no_to_wait", obs, HOLD);
            tick();
        end
        bus.mc_done_i = 1'b1;
        settle();
        chk("no_to_done", obs, NONE);
        tick();
        bus.mc_done_i = 1'b0;
        settle();
        chk("no_to_run", obs, NONE);
`endif

        // Async reset in FLUSH
        bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'h0000_0600;
        settle();
        chk("rf_jump", obs, JF | tmo);
        tick();
        bus.jump_en_i = 1'b0;
        settle();
        chk("rf_flush", obs, FL | tmo);
        rst = 1'b0;
        #1;
        chk("rf_reset", obs, NONE);
        tick();
        rst = 1'b1;
        settle();
        chk("rf_after", obs, NONE);
        bus.hold_flag_ex_i = 1'b1;
        settle();
        chk("rf_hold", obs, HOLD);
        tick();
        bus.hold_flag_ex_i = 1'b0;
        settle();
        chk("rf_hold_end", obs, NONE);

        // Async reset in HALT
        bus.halt_req_i = 1'b1;
        settle();
        chk("rh_req", obs, HOLD);
        tick();
        tick();
        settle();
        chk("rh_halted", obs, HOLD | HLTD);
        rst = 1'b0;
        #1;
        chk("rh_reset", obs, NONE);
        bus.halt_req_i = 1'b0;
        tick();
        rst = 1'b1;
        settle();
        chk("rh_after", obs, NONE);
        bus.hold_flag_ex_i = 1'b1;
        settle();
        chk("rh_hold", obs, HOLD);
        tick();
        bus.hold_flag_ex_i = 1'b0;
        settle();
        chk("rh_hold_end", obs, NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller between the execute stage and the front-end registers (pc_reg, if_id, id_ex).
- Takes jump and hold requests from ex, multi-cycle-unit start/done handshakes, and an external halt request.
- Produces the PC redirect, per-stage hold signals and the flush of wrong-path instructions.
- Owns all stall/flush sequencing so ex stays purely combinational.

Parameters:
- FLUSH_CYCLES, 2: number of cycles flush_o stays asserted after an accepted jump (1..15).
- MC_TIMEOUT, 64: maximum MC_WAIT cycles before a forced release (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- jump_en_i  input  1  jump/branch taken, from ex.
- jump_addr_i  input  32  jump target, from ex.
- hold_flag_ex_i  input  1  single-cycle hold request, from ex.
- mc_req_i  input  1  ex starts a multi-cycle operation (one-cycle pulse).
- mc_done_i  input  1  multi-cycle unit result valid (one-cycle pulse).
- halt_req_i  input  1  external halt request (level).
- jump_en_o  output  1  PC redirect enable, to pc_reg.
- jump_addr_o  output  32  PC redirect target.
- hold_pc_o  output  1  freeze pc_reg.
- hold_if_id_o  output  1  freeze if_id.
- hold_id_ex_o  output  1  freeze id_ex.
- flush_o  output  1  load NOP into if_id and id_ex.
- halted_o  output  1  core halted, registered.
- mc_timeout_o  output  1  sticky multi-cycle timeout flag, registered.

Behaviour:
- States: RUN, FLUSH, MC_WAIT, HALT. Reset (rst=0, asynchronous) forces RUN. Reset mid-operation aborts any flush, wait or halt with no residue.
- Outputs at reset: all outputs 0, including jump_addr_o=0, counters=0 and mc_timeout_o=0.
- Output timing: jump_en_o, jump_addr_o, hold_*_o and flush_o are combinational from state and inputs, i.e. same-cycle response. halted_o and mc_timeout_o are registered.
- jump_addr_o equals jump_addr_i when jump_en_o=1; otherwise it is 32'b0.
- RUN priority, highest first: jump > mc_req > hold_flag_ex > halt.
  - jump_en_i=1: jump_en_o=1 and flush_o=1 this cycle. If FLUSH_CYCLES>1, load flush_cnt=FLUSH_CYCLES-1 and go to FLUSH. Any mc_req_i or halt_req_i in the same cycle is dropped or deferred.
  - mc_req_i=1: hold_pc_o, hold_if_id_o and hold_id_ex_o =1 this cycle; go to MC_WAIT and clear wait_cnt.
  - hold_flag_ex_i=1: all three holds =1 this cycle only; stay in RUN.
  - halt_req_i=1: all holds =1; go to HALT.
- FLUSH:
  - flush_o=1 and holds=0; flush_cnt decrements each cycle; return to RUN when flush_cnt==1 on the transition edge.
  - A new jump_en_i during FLUSH is accepted: redirect again and reload flush_cnt=FLUSH_CYCLES-1.
  - halt_req_i during FLUSH is deferred until RUN.
- MC_WAIT:
  - All holds =1; jump_en_i and hold_flag_ex_i are ignored (jump_en_o=0).
  - On mc_done_i=1 the holds drop to 0 in that same cycle and the state goes to RUN.
  - halt_req_i is deferred until after done.
  - mc_req_i while already in MC_WAIT is ignored.
  - wait_cnt saturates at MC_TIMEOUT.
- HALT:
  - All holds =1, flush_o=0, jump_en_o=0.
  - halted_o goes to 1 on the cycle after HALT is entered.
  - When halt_req_i=0, return to RUN; holds drop in that cycle and halted_o clears on the next edge.
- mc_done_i outside MC_WAIT: ignored.

Optional Feature:
- Macro: PIPE_CTRL_MC_TIMEOUT_EN.
- When defined: in MC_WAIT, when wait_cnt reaches MC_TIMEOUT-1 with no mc_done_i, that cycle is forced as done (holds drop, go to RUN) and mc_timeout_o is set. mc_timeout_o is sticky until reset.
- When undefined: MC_WAIT waits indefinitely, wait_cnt logic is absent, and mc_timeout_o is tied to 0.

Test Plan:
- Jump with FLUSH_CYCLES=2: jump_en_i=1, jump_addr_i=0x0000_0100 for one cycle -> jump_en_o=1 and jump_addr_o=0x100 that cycle; flush_o=1 for exactly 2 cycles; holds stay 0; back in RUN.
- Multi-cycle wait: mc_req_i pulse, then mc_done_i 5 cycles later -> all holds high for 6 cycles including the req cycle, low in the done cycle; mc_timeout_o=0.
- Priority: jump_en_i, mc_req_i and halt_req_i all high in one cycle -> jump wins, FLUSH entered, no holds. With halt_req_i held high, HALT is entered after the flush and halted_o=1 one cycle later.
- Halt during multi-cycle: halt_req_i rises in MC_WAIT -> holds stay high, halted_o=0 until mc_done_i; HALT then entered; halt_req_i low -> RUN, halted_o clears next cycle.
- Timeout (macro on, MC_TIMEOUT=8): mc_req_i with no done -> holds released after 8 MC_WAIT cycles, mc_timeout_o=1 and sticky. With the macro off, holds remain high past 100 cycles.
- Async reset in FLUSH and in HALT: rst low mid-cycle -> all outputs 0 immediately; after release, a hold_flag_ex_i pulse gives a single-cycle hold.
